// File: rtl/sd_mem1p_arb.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// Latency: writes take effect at grant; read data is valid in the response slot 2 cycles after grant.
// Backpressure: a full or pending response slot blocks that port's reads; writes from the same port still go through.
module sd_mem1p_arb #(
  parameter int depth   = 256,
  parameter int width   = 8,
  parameter int addr_sz = $clog2(depth)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  // requester 0
  input  logic               c0_srdy_i,
  output logic               c0_drdy_o,
  input  logic               c0_wr_i,
  input  logic [addr_sz-1:0] c0_addr_i,
  input  logic [width-1:0]   c0_data_i,
  // requester 1
  input  logic               c1_srdy_i,
  output logic               c1_drdy_o,
  input  logic               c1_wr_i,
  input  logic [addr_sz-1:0] c1_addr_i,
  input  logic [width-1:0]   c1_data_i,
  // read response 0
  output logic               p0_srdy_o,
  input  logic               p0_drdy_i,
  output logic [width-1:0]   p0_data_o,
  // read response 1
  output logic               p1_srdy_o,
  input  logic               p1_drdy_i,
  output logic [width-1:0]   p1_data_o,
  // single-port memory
  output logic               mem_wr_en_o,
  output logic               mem_rd_en_o,
  output logic [addr_sz-1:0] mem_addr_o,
  output logic [width-1:0]   mem_d_in_o,
  input  logic [width-1:0]   mem_d_out_i
);

  // Round-robin pointer: 0 prefers port 0, 1 prefers port 1.
  logic             ptr_q, ptr_d;
  // A read was granted last cycle; memory data for it arrives this cycle.
  logic             inflt0_q, inflt0_d;
  logic             inflt1_q, inflt1_d;
  // Response slots.
  logic             p0_vld_q, p0_vld_d;
  logic             p1_vld_q, p1_vld_d;
  logic [width-1:0] p0_dat_q, p0_dat_d;
  logic [width-1:0] p1_dat_q, p1_dat_d;

  logic elig0, elig1;
  logic gnt0, gnt1;

  // Eligibility and round-robin grant; slot-free test uses registered state only.
  always_comb begin
    elig0 = c0_srdy_i & (c0_wr_i | (~p0_vld_q & ~inflt0_q));
    elig1 = c1_srdy_i & (c1_wr_i | (~p1_vld_q & ~inflt1_q));
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (!reset_i) begin
      if (elig0 && elig1) begin
        if (ptr_q) gnt1 = 1'b1;
        else       gnt0 = 1'b1;
      end else if (elig0) begin
        gnt0 = 1'b1;
      end else if (elig1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Memory strobes and handshakes follow the single winner.
  always_comb begin
    c0_drdy_o   = gnt0;
    c1_drdy_o   = gnt1;
    mem_wr_en_o = (gnt0 & c0_wr_i) | (gnt1 & c1_wr_i);
    mem_rd_en_o = (gnt0 & ~c0_wr_i) | (gnt1 & ~c1_wr_i);
    mem_addr_o  = gnt1 ? c1_addr_i : c0_addr_i;
    mem_d_in_o  = gnt1 ? c1_data_i : c0_data_i;
    p0_srdy_o   = p0_vld_q;
    p1_srdy_o   = p1_vld_q;
    p0_data_o   = p0_dat_q;
    p1_data_o   = p1_dat_q;
  end

  // Next-state: pointer flips away from the winner, in-flight tracks read grants,
  // slots capture memory data the cycle after the grant and drain on drdy.
  always_comb begin
    ptr_d    = ptr_q;
    if (gnt0)      ptr_d = 1'b1;
    else if (gnt1) ptr_d = 1'b0;

    inflt0_d = gnt0 & ~c0_wr_i;
    inflt1_d = gnt1 & ~c1_wr_i;

    p0_vld_d = p0_vld_q;
    p0_dat_d = p0_dat_q;
    if (inflt0_q) begin
      p0_vld_d = 1'b1;
      p0_dat_d = mem_d_out_i;
    end else if (p0_vld_q && p0_drdy_i) begin
      p0_vld_d = 1'b0;
    end

    p1_vld_d = p1_vld_q;
    p1_dat_d = p1_dat_q;
    if (inflt1_q) begin
      p1_vld_d = 1'b1;
      p1_dat_d = mem_d_out_i;
    end else if (p1_vld_q && p1_drdy_i) begin
      p1_vld_d = 1'b0;
    end
  end

  // State registers; reset drops any pending read and empties both slots.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q    <= 1'b0;
      inflt0_q <= 1'b0;
      inflt1_q <= 1'b0;
      p0_vld_q <= 1'b0;
      p1_vld_q <= 1'b0;
      p0_dat_q <= '0;
      p1_dat_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      inflt0_q <= inflt0_d;
      inflt1_q <= inflt1_d;
      p0_vld_q <= p0_vld_d;
      p1_vld_q <= p1_vld_d;
      p0_dat_q <= p0_dat_d;
      p1_dat_q <= p1_dat_d;
    end
  end

endmodule
